// File: rtl/elevator_pkg.sv
// Shared elevator types: simulation mode, dwell FSM states, shaft geometry.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package elevator_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    SIM    = 2'd1,
    PAUSE  = 2'd2,
    ENDING = 2'd3
  } state_t;

  localparam int NUM_FLOORS   = 6;
  localparam int MAX_HALF_POS = 10;

  typedef enum logic {
    DW_IDLE  = 1'b0,
    DW_DWELL = 1'b1
  } dwell_state_t;

  // Distance in half-floor units between a car position and floor f (at 2f).
  function automatic logic [4:0] half_dist(input logic [3:0] pos, input logic [2:0] floor_idx);
    logic [4:0] a;
    logic [4:0] b;
    a = {1'b0, pos};
    b = {1'b0, floor_idx, 1'b0};
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/door_dwell_timer.sv
// Per-car door dwell: opens at a flagged floor, counts DWELL_CYCLES, then clears that stop.
// Latency: door_open one edge after arriving at a flagged floor; served/clear on the last count edge.
// Backpressure: none; freeze holds state and count, sclr returns to idle.
module door_dwell_timer #(
  parameter int NF           = 6,
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    pos,
  input  logic [NF-1:0] floor_bits,
  input  logic          en,
  input  logic          freeze,
  input  logic          sclr,
  output logic          door_open,
  output logic          served,
  output logic          clr_vld,
  output logic [2:0]    clr_idx
);
  import elevator_pkg::*;

  dwell_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       floor_q, floor_d;
  logic             served_q, served_d;

  logic [7:0]       bits_ext;
  logic             at_flagged;
  logic             last_cnt;

  assign bits_ext   = 8'(floor_bits);
  // Only an exact floor stop (even half-position) inside the shaft can trigger a dwell.
  assign at_flagged = !pos[0] && (pos <= 4'(MAX_HALF_POS)) &&
                      (int'(pos[3:1]) < NF) && bits_ext[pos[3:1]];
  assign last_cnt   = (cnt_q == CNT_W'(DWELL_CYCLES - 1));

  // Next-state logic: enter on a flagged floor, count, clear the latched stop on the last count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    floor_d  = floor_q;
    served_d = 1'b0;
    clr_vld  = 1'b0;
    if (sclr) begin
      state_d = DW_IDLE;
      cnt_d   = '0;
      floor_d = '0;
    end else if (!freeze) begin
      case (state_q)
        DW_IDLE: begin
          if (en && at_flagged) begin
            state_d = DW_DWELL;
            cnt_d   = '0;
            floor_d = pos[3:1];
          end
        end
        DW_DWELL: begin
          if (last_cnt) begin
            clr_vld  = 1'b1;
            served_d = 1'b1;
            state_d  = DW_IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // State, counter, latched stop floor and served pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DW_IDLE;
      cnt_q    <= '0;
      floor_q  <= '0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      served_q <= served_d;
    end
  end

  assign door_open = (state_q == DW_DWELL);
  assign served    = served_q;
  assign clr_idx   = floor_q;

endmodule

// File: rtl/floor_request_manager.sv
// Latches hall/car presses, assigns hall calls to the nearer car, clears stops after door dwell.
// Latency: 1 edge from press to FloorsRequested/FloorDestinations; dwell outputs registered.
// Backpressure: none; presses are single-cycle pulses, duplicates are absorbed.
module floor_request_manager #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              simState,
  input  logic [NUM_FLOORS-1:0]   hall_btn,
  input  logic [2*NUM_FLOORS-1:0] car_btn,
  input  logic [7:0]              half_elevatorPositions,
  input  logic [1:0]              directions,
  output logic [2*NUM_FLOORS-1:0] FloorsRequested,
  output logic [2*NUM_FLOORS-1:0] FloorDestinations,
  output logic [1:0]              door_open,
  output logic [1:0]              served
);
  import elevator_pkg::*;

  state_t                  mode;
  logic [2*NUM_FLOORS-1:0] req_q, req_d;
  logic [2*NUM_FLOORS-1:0] dest_q, dest_d;
  logic [3:0]              pos [2];
  logic [1:0]              clr_vld;
  logic [2:0]              clr_idx [2];
  logic                    unused_dirs;

  assign mode   = state_t'(simState);
  assign pos[0] = half_elevatorPositions[3:0];
  assign pos[1] = half_elevatorPositions[7:4];

  // Direction is only logged downstream; it has no effect on assignment here.
  assign unused_dirs = ^directions;

  for (genvar e = 0; e < 2; e++) begin : g_car
    door_dwell_timer #(
      .NF           (NUM_FLOORS),
      .DWELL_CYCLES (DWELL_CYCLES),
      .CNT_W        (CNT_W)
    ) u_dwell (
      .clk        (clk),
      .rst        (rst),
      .pos        (pos[e]),
      .floor_bits (req_q[e*NUM_FLOORS +: NUM_FLOORS] | dest_q[e*NUM_FLOORS +: NUM_FLOORS]),
      .en         (mode == SIM),
      .freeze     (mode == PAUSE),
      .sclr       (mode == START),
      .door_open  (door_open[e]),
      .served     (served[e]),
      .clr_vld    (clr_vld[e]),
      .clr_idx    (clr_idx[e])
    );
  end

  // Request update: presses set bits, then dwell clears override so a boarding press is absorbed.
  always_comb begin
    req_d  = req_q;
    dest_d = dest_q;
    if (mode == START) begin
      req_d  = '0;
      dest_d = '0;
    end else begin
      if (mode == SIM) begin
        dest_d = dest_q | car_btn;
        for (int f = 0; f < NUM_FLOORS; f++) begin
          if (hall_btn[f] && !req_q[f] && !req_q[NUM_FLOORS+f]) begin
            // Tie goes to the left car.
            if (half_dist(pos[0], 3'(f)) <= half_dist(pos[1], 3'(f))) begin
              req_d[f] = 1'b1;
            end else begin
              req_d[NUM_FLOORS+f] = 1'b1;
            end
          end
        end
      end
      for (int e = 0; e < 2; e++) begin
        if (clr_vld[e]) begin
          req_d[e*NUM_FLOORS + int'(clr_idx[e])]  = 1'b0;
          dest_d[e*NUM_FLOORS + int'(clr_idx[e])] = 1'b0;
        end
      end
    end
  end

  // Request and destination registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= '0;
      dest_q <= '0;
    end else begin
      req_q  <= req_d;
      dest_q <= dest_d;
    end
  end

  assign FloorsRequested   = req_q;
  assign FloorDestinations = dest_q;

endmodule

// File: tb/tb_floor_request_manager.sv
// Directed bench: table of single-edge vectors plus hand-written dwell/pause/reset sequences.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_floor_request_manager;

  logic        clk;
  logic        rst;
  logic [1:0]  simState;
  logic [5:0]  hall_btn;
  logic [11:0] car_btn;
  logic [7:0]  half_elevatorPositions;
  logic [1:0]  directions;
  logic [11:0] FloorsRequested;
  logic [11:0] FloorDestinations;
  logic [1:0]  door_open;
  logic [1:0]  served;

  floor_request_manager #(.NUM_FLOORS(6), .DWELL_CYCLES(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .simState               (simState),
    .hall_btn               (hall_btn),
    .car_btn                (car_btn),
    .half_elevatorPositions (half_elevatorPositions),
    .directions             (directions),
    .FloorsRequested        (FloorsRequested),
    .FloorDestinations      (FloorDestinations),
    .door_open              (door_open),
    .served                 (served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] M_START = 2'd0, M_SIM = 2'd1, M_PAUSE = 2'd2, M_END = 2'd3;

  typedef struct {
    logic [1:0]  mode;
    logic [5:0]  hall;
    logic [11:0] car;
    logic [3:0]  pl;
    logic [3:0]  pr;
    logic [11:0] exp_req;
    logic [11:0] exp_dest;
    logic [1:0]  exp_door;
    logic [1:0]  exp_served;
  } vec_t;

  vec_t vecs [11];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [11:0] req, input logic [11:0] dest,
                         input logic [1:0] door, input logic [1:0] srv);
    chk({name, ".req"},    32'(FloorsRequested),   32'(req));
    chk({name, ".dest"},   32'(FloorDestinations), 32'(dest));
    chk({name, ".door"},   32'(door_open),         32'(door));
    chk({name, ".served"}, 32'(served),            32'(srv));
  endtask

  task automatic drive(input logic [1:0] m, input logic [5:0] h, input logic [11:0] c,
                       input logic [3:0] pl, input logic [3:0] pr);
    simState               = m;
    hall_btn               = h;
    car_btn                = c;
    half_elevatorPositions = {pr, pl};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mode, hall, car, posL, posR, req, dest, door, served
    vecs[0]  = '{M_SIM,   6'h00, 12'h008, 4'd0,  4'd10, 12'h000, 12'h008, 2'b00, 2'b00};
    vecs[1]  = '{M_SIM,   6'h10, 12'h000, 4'd0,  4'd10, 12'h400, 12'h008, 2'b00, 2'b00};
    vecs[2]  = '{M_SIM,   6'h10, 12'h000, 4'd8,  4'd0,  12'h400, 12'h008, 2'b00, 2'b00};
    vecs[3]  = '{M_SIM,   6'h04, 12'h000, 4'd4,  4'd4,  12'h404, 12'h008, 2'b00, 2'b00};
    vecs[4]  = '{M_SIM,   6'h00, 12'h000, 4'd1,  4'd1,  12'h404, 12'h008, 2'b00, 2'b00};
    vecs[5]  = '{M_SIM,   6'h21, 12'h000, 4'd1,  4'd9,  12'hC05, 12'h008, 2'b00, 2'b00};
    vecs[6]  = '{M_PAUSE, 6'h3F, 12'hFFF, 4'd1,  4'd9,  12'hC05, 12'h008, 2'b00, 2'b00};
    vecs[7]  = '{M_END,   6'h3F, 12'h020, 4'd1,  4'd9,  12'hC05, 12'h008, 2'b00, 2'b00};
    vecs[8]  = '{M_START, 6'h00, 12'h000, 4'd1,  4'd9,  12'h000, 12'h000, 2'b00, 2'b00};
    vecs[9]  = '{M_SIM,   6'h00, 12'h040, 4'd1,  4'd1,  12'h000, 12'h040, 2'b00, 2'b00};
    vecs[10] = '{M_SIM,   6'h02, 12'h000, 4'd7,  4'd1,  12'h080, 12'h040, 2'b00, 2'b00};

    directions = 2'b00;
    drive(M_START, 6'h00, 12'h000, 4'd0, 4'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_all("reset", 12'h000, 12'h000, 2'b00, 2'b00);
    @(negedge clk) rst = 1'b1;
    tick();

    // Single-edge vectors: presses, assignment, ties, gating by mode.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].mode, vecs[i].hall, vecs[i].car, vecs[i].pl, vecs[i].pr);
      directions = 2'(i);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_dest,
              vecs[i].exp_door, vecs[i].exp_served);
    end

    // Full left-car dwell at floor 2.
    drive(M_START, 6'h00, 12'h000, 4'd5, 4'd1);
    tick();
    drive(M_SIM, 6'h00, 12'h004, 4'd5, 4'd1);
    tick();
    chk_all("dwell.latch", 12'h000, 12'h004, 2'b00, 2'b00);
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dwell.open%0d", i), 32'(door_open), 32'(2'b01));
      chk($sformatf("dwell.nosrv%0d", i), 32'(served), 32'(2'b00));
      tick();
    end
    chk_all("dwell.clear", 12'h000, 12'h000, 2'b00, 2'b01);
    tick();
    chk("dwell.srv_pulse", 32'(served), 32'(2'b00));

    // Press in the clear cycle is swallowed; press one cycle later re-opens.
    drive(M_SIM, 6'h00, 12'h004, 4'd4, 4'd1);
    tick();
    chk_all("board.latch", 12'h000, 12'h004, 2'b00, 2'b00);
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd1);
    tick();
    chk("board.open", 32'(door_open), 32'(2'b01));
    repeat (7) tick();
    drive(M_SIM, 6'h00, 12'h004, 4'd4, 4'd1);
    tick();
    chk_all("board.clrwins", 12'h000, 12'h000, 2'b00, 2'b01);
    tick();
    chk_all("board.relatch", 12'h000, 12'h004, 2'b00, 2'b00);
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd1);
    tick();
    chk("board.reopen", 32'(door_open), 32'(2'b01));

    // Pause at count 3 for five edges, then five more edges in SIM to clear.
    repeat (3) tick();
    drive(M_PAUSE, 6'h01, 12'h800, 4'd4, 4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("pause%0d", i), 12'h000, 12'h004, 2'b01, 2'b00);
    end
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd1);
    repeat (4) tick();
    chk_all("resume.hold", 12'h000, 12'h004, 2'b01, 2'b00);
    tick();
    chk_all("resume.clear", 12'h000, 12'h000, 2'b00, 2'b01);

    // Right-car dwell at floor 1.
    tick();
    drive(M_SIM, 6'h00, 12'h080, 4'd4, 4'd2);
    tick();
    chk_all("right.latch", 12'h000, 12'h080, 2'b00, 2'b00);
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd2);
    tick();
    chk("right.open", 32'(door_open), 32'(2'b10));
    repeat (7) tick();
    chk("right.hold", 32'(door_open), 32'(2'b10));
    tick();
    chk_all("right.clear", 12'h000, 12'h000, 2'b00, 2'b10);

    // Pending bits cleared by START.
    drive(M_SIM, 6'h08, 12'h081, 4'd1, 4'd3);
    tick();
    chk_all("pend", 12'h200, 12'h081, 2'b00, 2'b00);
    drive(M_START, 6'h00, 12'h000, 4'd1, 4'd3);
    tick();
    chk_all("start", 12'h000, 12'h000, 2'b00, 2'b00);

    // Asynchronous reset in the middle of a dwell.
    drive(M_SIM, 6'h00, 12'h004, 4'd4, 4'd1);
    tick();
    drive(M_SIM, 6'h00, 12'h000, 4'd4, 4'd1);
    tick();
    chk("rstdw.open", 32'(door_open), 32'(2'b01));
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 chk_all("rstdw.async", 12'h000, 12'h000, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("rstdw.held%0d", i), 12'h000, 12'h000, 2'b00, 2'b00);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    chk_all("rstdw.release", 12'h000, 12'h000, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
